pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 8-bit combinational RCA.
- Operand width is split into STAGES equal slices. Each slice ripples through one full-adder chain per stage, with carry registered between stages.
- Valid/ready handshake on input and output, full backpressure.
- Sits on the datapath between operand registers and result consumers (ALU, accumulators).

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- STAGES, 2, pipeline stages; WIDTH % STAGES == 0 required (elaboration-time check, fatal otherwise); slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/mode present.
- in_ready  output  1  block can accept this cycle.
- A  input  WIDTH  operand A (unsigned/two's-complement agnostic).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0: A+B+Cin; 1: A−B−Cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- CarryOut  output  1  raw carry out of MSB.
- Overflow  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, so out_valid=0; Sum=0, CarryOut=0, Overflow=0; data registers cleared.
- Reset mid-operation discards all in-flight transactions. After release, no output appears until new inputs are accepted.
- Operand conditioning at acceptance: Bx = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin. So Sub=1 gives A + ~B + !Cin.
- Slice k (0..STAGES−1) covers bits [k*SW +: SW], computed by an SW-bit full-adder ripple chain.
  - Stage 0 uses c0.
  - Stage k uses the carry registered by stage k−1.
  - Not-yet-processed upper operand slices and already-computed lower sum slices are carried forward in per-stage registers.
- Advance condition: advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_valid/out_ready).
  - When advance=1 every stage register loads from its predecessor. Stage 0 loads the new operands with valid = in_valid.
  - When advance=0 all stages hold. Sum, CarryOut, Overflow and out_valid are stable while out_valid && !out_ready.
- Bubbles are not collapsed: the pipeline is a rigid shift register of STAGES entries.
- Latency: a transaction accepted at rising edge t drives out_valid=1 with its result immediately after edge t+STAGES−1, i.e. visible in cycle t+STAGES−1 (STAGES=1 gives a result in the cycle after acceptance).
- Throughput: one transaction/cycle while out_ready=1.
- Result flags:
  - CarryOut = carry out of bit WIDTH−1. For Sub this equals NOT borrow.
  - Overflow = carry into MSB XOR carry out of MSB.
- Simultaneous accept and emit in one cycle is legal and lossless.
- Sum wraps modulo 2^WIDTH; no saturation.
- When out_valid=0, Sum/CarryOut/Overflow hold their last values (don't-care for checkers).
- Inputs are sampled only when in_valid && in_ready. Otherwise they are ignored, and Sub/Cin are not retained.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Add with carry out: A=0xC8, B=0x64, Cin=0, Sub=0, out_ready=1 → one cycle after acceptance: Sum=0x2C, CarryOut=1, Overflow=0.
- Signed overflow: A=0x7F, B=0x01 → Sum=0x80, CarryOut=0, Overflow=1. Carry-in case: A=0xFF, B=0x00, Cin=1 → Sum=0x00, CarryOut=1, Overflow=0.
- Subtract: A=0x05, B=0x07, Cin=0, Sub=1 → Sum=0xFE, CarryOut=0 (borrow), Overflow=0. Same operands with Cin=1 → Sum=0xFD.
- Backpressure: stream 3 adds (1+1, 2+2, 3+3) back-to-back; hold out_ready=0 for 3 cycles once first result valid → in_ready=0 during hold, outputs stable at 0x02; on release, results 0x02, 0x04, 0x06 emerge in order, one per cycle, none lost or duplicated.
- Reset mid-flight: accept 2 transactions, assert rst_n=0 between clock edges → out_valid, Sum, CarryOut, Overflow drop to 0 immediately (asynchronously); after release, out_valid stays 0 until new input accepted.
- Parameter sweep: WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1 → 1000 random add/sub transactions with random in_valid/out_ready match the reference model A±B±Cin (Sum, CarryOut, Overflow). Latency equals STAGES−1 cycles after the accept edge; in-order delivery.

Source files
------------

// File: rtl/pipelined_rca.sv
// pipelined_rca: ripple-carry adder/subtractor split into STAGES slices of WIDTH/STAGES bits,
// carry registered between slices, valid/ready handshake with full backpressure.
module pipelined_rca #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);
    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_chk
        $fatal(1, "pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
    end

    function automatic logic [SW:0] ripple(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
        logic [SW:0] r;
        logic        c;
        c = ci;
        for (int i = 0; i < SW; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[SW] = c;
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bx;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bx       = Sub ? ~B : B;

    // d_q holds finished sum slices below slice k and still-unused A bits above it
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - (k + 1) * SW;
        logic             v_i, c_i, v_q, c_q;
        logic [WIDTH-1:0] d_i, d_q;
        logic [SW-1:0]    y;
        logic [SW:0]      r;

        if (k == 0) begin : g_src
            assign v_i = in_valid;
            assign c_i = Sub ^ Cin;
            assign d_i = A;
            assign y   = bx[SW-1:0];
        end else begin : g_src
            assign v_i = g_st[k-1].v_q;
            assign c_i = g_st[k-1].c_q;
            assign d_i = g_st[k-1].d_q;
            assign y   = g_st[k-1].g_b.b_q[SW-1:0];
        end

        assign r = ripple(d_i[k*SW +: SW], y, c_i);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                d_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                if (v_i) begin
                    d_q              <= d_i;
                    d_q[k*SW +: SW]  <= r[SW-1:0];
                    c_q              <= r[SW];
                end
            end
        end

        // conditioned B bits not yet consumed, shifted down so the next slice sits at the bottom
        if (k < STAGES - 1) begin : g_b
            logic [RW-1:0] b_n, b_q;
            if (k == 0) begin : g_bs
                assign b_n = bx[WIDTH-1:SW];
            end else begin : g_bs
                assign b_n = g_st[k-1].g_b.b_q[RW+SW-1:SW];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) b_q <= '0;
                else if (adv && v_i) b_q <= b_n;
            end
        end

        // carry into the MSB is recovered as a ^ b ^ sum of that bit
        if (k == STAGES - 1) begin : g_ov
            logic o_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) o_q <= 1'b0;
                else if (adv && v_i) o_q <= d_i[WIDTH-1] ^ y[SW-1] ^ r[SW-1] ^ r[SW];
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign Sum       = g_st[STAGES-1].d_q;
    assign CarryOut  = g_st[STAGES-1].c_q;
    assign Overflow  = g_st[STAGES-1].g_ov.o_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed vectors and corner sequences on 8/2, random sweeps on 16/4 and 8/1,
// all outputs checked against a scoreboard fed by a behavioural A +/- B +/- Cin model.
module tb_pipelined_rca;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    bit  sweep_go = 1'b0;

    logic       m_iv, m_or, m_cin, m_sub, m_ir, m_vo, m_co, m_ov;
    logic [7:0] m_a, m_b, m_sum;

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [32:0] m, bxx, f;
        logic [31:0] s;
        logic        co, ov;
        m   = (33'd1 << w) - 33'd1;
        bxx = sub ? (~{1'b0, b}) & m : {1'b0, b} & m;
        f   = {1'b0, a} + bxx + {32'b0, sub ^ cin};
        s   = f[31:0] & m[31:0];
        co  = f[w];
        ov  = (a[w-1] == bxx[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_d
        localparam int W = (g == 1) ? 16 : 8;
        localparam int S = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        logic          iv, ir, vo, ro, cin, sub, co, ovf;
        logic [W-1:0]  a, b, sum;
        logic [33:0]   q[$];
        int            aq[$];
        int            acc = 0;
        int            adv_n = 0;
        bit            done = 1'b0;
        logic [33:0]   e;
        int            i0;

        pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
            .Cin(cin), .Sub(sub), .out_valid(vo), .out_ready(ro), .Sum(sum),
            .CarryOut(co), .Overflow(ovf)
        );

        // latency is counted in advancing edges so stalls do not disturb the check
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                aq.delete();
            end else begin
                if (vo && ro) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL c%0d_spurious actual=%0h required=none", g, sum);
                    end else begin
                        e  = q.pop_front();
                        i0 = aq.pop_front();
                        chk($sformatf("c%0d_sum", g), 32'(sum), 32'(e[W-1:0]));
                        chk($sformatf("c%0d_co", g), 32'(co), 32'(e[32]));
                        chk($sformatf("c%0d_ov", g), 32'(ovf), 32'(e[33]));
                        chk($sformatf("c%0d_lat", g), 32'(adv_n - 1 - i0), 32'(S - 1));
                    end
                end
                if (iv && ir) begin
                    q.push_back(model(32'(a), 32'(b), cin, sub, W));
                    aq.push_back(adv_n);
                    acc++;
                end
                if (ir) adv_n++;
            end
        end

        if (g == 0) begin : g_m
            assign iv    = m_iv;
            assign ro    = m_or;
            assign a     = m_a;
            assign b     = m_b;
            assign cin   = m_cin;
            assign sub   = m_sub;
            assign m_ir  = ir;
            assign m_vo  = vo;
            assign m_sum = sum;
            assign m_co  = co;
            assign m_ov  = ovf;
        end else begin : g_r
            initial begin
                iv = 1'b0; ro = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
                wait (sweep_go);
                for (int c = 0; c < 20000 && acc < 1000; c++) begin
                    @(posedge clk);
                    #1;
                    iv  = $urandom_range(0, 3) != 0;
                    ro  = $urandom_range(0, 3) != 0;
                    a   = W'($urandom);
                    b   = W'($urandom);
                    cin = 1'($urandom);
                    sub = 1'($urandom);
                end
                @(posedge clk);
                #1;
                iv = 1'b0;
                ro = 1'b1;
                for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
                chk($sformatf("c%0d_count", g), 32'(acc >= 1000), 32'd1);
                chk($sformatf("c%0d_drain", g), 32'(q.size()), 32'd0);
                done = 1'b1;
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        m_a = a; m_b = b; m_cin = c; m_sub = s; m_iv = 1'b1;
    endtask

    initial begin
        tv[0] = '{8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0};
        tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tv[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0};
        tv[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tv[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tv[8] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[9] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        m_iv = 1'b0; m_or = 1'b1; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(m_vo), 32'd0);
        chk("rst_sum", 32'(m_sum), 32'd0);
        chk("rst_co", 32'(m_co), 32'd0);
        chk("rst_ov", 32'(m_ov), 32'd0);
        chk("rst_in_ready", 32'(m_ir), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
            @(posedge clk);
            #1;
            m_iv = 1'b0; m_a = 8'($urandom); m_b = 8'($urandom);
            chk($sformatf("v%0d_early", i), 32'(m_vo), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(m_vo), 32'd1);
            chk($sformatf("v%0d_sum", i), 32'(m_sum), 32'(tv[i].s));
            chk($sformatf("v%0d_co", i), 32'(m_co), 32'(tv[i].co));
            chk($sformatf("v%0d_ov", i), 32'(m_ov), 32'(tv[i].ov));
        end
        @(posedge clk);
        #1;
        chk("bp_idle", 32'(m_vo), 32'd0);
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(8'h02, 8'h02, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(8'h03, 8'h03, 1'b0, 1'b0);
        m_or = 1'b0;
        chk("bp_first_valid", 32'(m_vo), 32'd1);
        chk("bp_first_sum", 32'(m_sum), 32'h02);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_ready", i), 32'(m_ir), 32'd0);
            chk($sformatf("bp_hold%0d_valid", i), 32'(m_vo), 32'd1);
            chk($sformatf("bp_hold%0d_sum", i), 32'(m_sum), 32'h02);
        end
        m_or = 1'b1;
        #1 chk("bp_release_ready", 32'(m_ir), 32'd1);
        @(posedge clk);
        #1 m_iv = 1'b0;
        chk("bp_r1_valid", 32'(m_vo), 32'd1);
        chk("bp_r1_sum", 32'(m_sum), 32'h04);
        @(posedge clk);
        #1;
        chk("bp_r2_valid", 32'(m_vo), 32'd1);
        chk("bp_r2_sum", 32'(m_sum), 32'h06);
        @(posedge clk);
        #1 chk("bp_r3_valid", 32'(m_vo), 32'd0);
        drive(8'h90, 8'h90, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1 m_iv = 1'b0;
        chk("mid_pre_sum", 32'(m_sum), 32'h20);
        chk("mid_pre_co", 32'(m_co), 32'd1);
        chk("mid_pre_ov", 32'(m_ov), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_vo), 32'd0);
        chk("mid_rst_sum", 32'(m_sum), 32'd0);
        chk("mid_rst_co", 32'(m_co), 32'd0);
        chk("mid_rst_ov", 32'(m_ov), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk($sformatf("post_rst%0d_valid", i), 32'(m_vo), 32'd0);
        end
        drive(8'h0A, 8'h05, 1'b0, 1'b1);
        @(posedge clk);
        #1 m_iv = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_new_valid", 32'(m_vo), 32'd1);
        chk("post_rst_new_sum", 32'(m_sum), 32'h05);
        chk("post_rst_new_co", 32'(m_co), 32'd1);
        @(posedge clk);
        sweep_go = 1'b1;
        for (int i = 0; i < 25000 && !(g_d[1].done && g_d[2].done); i++) @(posedge clk);
        chk("sweep_done", {30'b0, g_d[1].done, g_d[2].done}, 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
